axi4lite_master: RTL and testbench
==================================

AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
- REQ-001 SHALL have no parameters; all widths are fixed.
- REQ-002 ACLK  in  1  single clock; all state changes on the rising edge.
- REQ-003 ARESETn  in  1  asynchronous, active-high reset: asserted at 1 despite the suffix.
- REQ-004 start  in  1  request strobe; sampled only in IDLE.
- REQ-005 write  in  1  request type: 1 = write, 0 = read.
- REQ-006 addr  in  32  request address.
- REQ-007 wdata  in  32  write data.
- REQ-008 wstrb  in  4  write byte strobes.
- REQ-009 busy  out  1  high while a transaction is in flight.
- REQ-010 done  out  1  one-cycle completion pulse.
- REQ-011 rdata  out  32  last read data, held.
- REQ-012 resp  out  2  last BRESP or RRESP, held.
- REQ-013 The AXI4-Lite channel ports SHALL be as follows:
  - AWADDR out 32, AWVALID out 1, AWREADY in 1.
  - WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1.
  - BRESP in 2, BVALID in 1, BREADY out 1.
  - ARADDR out 32, ARVALID out 1, ARREADY in 1.
  - RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1.

Function
- REQ-014 The FSM SHALL have the states IDLE, WRITE, WRESP, RADDR, RDATA and DONE, encoded in a register named state.
- REQ-015 In IDLE with start=1, the block SHALL latch addr, wdata, wstrb and write, set busy=1, and go to WRITE (write=1) or RADDR (write=0) at that edge.
- REQ-016 WRITE entry SHALL assert AWVALID and WVALID together in the cycle after start.
  - AWADDR and WDATA/WSTRB come from the latched values and stay stable while VALID is high.
- REQ-017 The AW and W channels SHALL complete independently.
  - Each VALID drops on the edge where VALID && READY.
  - WRITE exits to WRESP once both handshakes are done, including when both happen on the same edge.
- REQ-018 WRESP SHALL hold BREADY=1; on BVALID && BREADY it captures BRESP into resp and goes to DONE.
- REQ-019 RADDR SHALL hold ARVALID=1 with ARADDR = latched address, and go to RDATA on ARREADY.
- REQ-020 RDATA SHALL hold RREADY=1; on RVALID it captures RDATA into rdata and RRESP into resp, then goes to DONE.
- REQ-021 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
- REQ-022 A start sampled outside IDLE SHALL be ignored; the latched request is unaffected by input changes after acceptance.
- REQ-023 VALID signals SHALL never depend combinationally on READY inputs; all outputs are registered.
- REQ-024 No timeout SHALL exist: the block waits indefinitely for READY or VALID.
- REQ-025 resp and rdata SHALL be non-zero-extended, unmodified slave values; a non-OKAY response still completes normally.

Reset
- REQ-026 ARESETn=1 SHALL immediately force state=IDLE and clear all outputs to 0:
  - AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done.
  - AWADDR, WDATA, WSTRB, ARADDR, rdata, resp.
- REQ-027 Reset asserted mid-transaction SHALL abort it without a done pulse; after release the block is in IDLE and accepts a new start.

Configuration
- REQ-028 Macro AXI4LITE_MASTER_READ_EN defined: the read path (RADDR/RDATA) SHALL be compiled in as specified.
- REQ-029 Macro AXI4LITE_MASTER_READ_EN undefined: ARVALID and RREADY SHALL be tied 0, and a read request goes straight to DONE (busy for 1 cycle) with resp=2'b10 (SLVERR) and rdata unchanged.

Verification
- REQ-030 Write with a zero-wait slave: addr=32'h1000_0000, wdata=32'hDEADBEEF, wstrb=4'hF, start for 1 cycle.
  - AWVALID and WVALID rise together; both see READY one cycle later; BVALID with BRESP=2'b00.
  - Required response: done pulses once, resp=2'b00, busy low afterwards.
- REQ-031 Skewed write: AWREADY 1 cycle late, WREADY 3 cycles late.
  - Required response: AWVALID drops first, WVALID holds until its handshake, and BREADY asserts only after both handshakes.
- REQ-032 Read (READ_EN defined): addr=32'h2000_0004, ARREADY after 2 cycles, RDATA=32'hCAFEF00D, RRESP=2'b00.
  - Required response: rdata=32'hCAFEF00D, resp=2'b00, one done pulse.
- REQ-033 Write with BRESP=2'b10 plus a second start pulse during busy.
  - Required response: resp=2'b10, and only one transaction is issued.
- REQ-034 Reset while WVALID is waiting on WREADY=0.
  - Required response: all outputs are 0 immediately with no done pulse; a subsequent write completes normally.
- REQ-035 Read with READ_EN undefined.
  - Required response: ARVALID never rises, and done pulses 2 cycles after start with resp=2'b10.

Source files
------------

// File: rtl/axi4lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_master
//  Purpose  : Single-outstanding AXI4-Lite master. A one-cycle 'start' in IDLE
//             launches one write (AW+W then B) or one read (AR then R).
//             The result is reported with a one-cycle 'done' pulse, and
//             'resp'/'rdata' hold the slave's last response.
//  Clock    : ACLK. All state changes on the rising edge.
//  Reset    : ARESETn. Asynchronous and active-high (asserted at 1).
//  Ports    : start/write/addr/wdata/wstrb are request inputs.
//             busy/done/rdata/resp are status outputs.
//             AW*, W*, B*, AR*, R* form the AXI4-Lite master channels.
//             All outputs are registered.
//  Config   : AXI4LITE_MASTER_READ_EN
//             - defined   : full read path (RADDR -> RDATA).
//             - undefined : ARVALID/RREADY stay 0. A read completes after one
//                           busy cycle with resp = SLVERR and rdata unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4lite_master (
  input  logic        ACLK,
  input  logic        ARESETn,
  // request side
  input  logic        start,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  // write address channel
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  // write data channel
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  // write response channel
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // read address channel
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  // read data channel
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  state_t      state;
  state_t      w_state_nxt;

  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [31:0] w_rdata_nxt;
  logic [1:0]  w_resp_nxt;
  logic [31:0] w_awaddr_nxt;
  logic        w_awvalid_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_wstrb_nxt;
  logic        w_wvalid_nxt;
  logic        w_bready_nxt;
  logic [31:0] w_araddr_nxt;
  logic        w_arvalid_nxt;
  logic        w_rready_nxt;

`ifndef AXI4LITE_MASTER_READ_EN
  // The read channel inputs have no consumer when the read path is compiled out.
  logic w_unused_rd;
  assign w_unused_rd = ^{ARREADY, RDATA, RRESP, RVALID};
`endif

  // State and every output are registered.
  // VALIDs therefore never follow READY combinationally.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 32'd0;
      resp    <= 2'b00;
      AWADDR  <= 32'd0;
      AWVALID <= 1'b0;
      WDATA   <= 32'd0;
      WSTRB   <= 4'd0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARADDR  <= 32'd0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
    end else begin
      state   <= w_state_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      rdata   <= w_rdata_nxt;
      resp    <= w_resp_nxt;
      AWADDR  <= w_awaddr_nxt;
      AWVALID <= w_awvalid_nxt;
      WDATA   <= w_wdata_nxt;
      WSTRB   <= w_wstrb_nxt;
      WVALID  <= w_wvalid_nxt;
      BREADY  <= w_bready_nxt;
      ARADDR  <= w_araddr_nxt;
      ARVALID <= w_arvalid_nxt;
      RREADY  <= w_rready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = state;
    w_busy_nxt    = busy;
    w_done_nxt    = done;
    w_rdata_nxt   = rdata;
    w_resp_nxt    = resp;
    w_awaddr_nxt  = AWADDR;
    w_awvalid_nxt = AWVALID;
    w_wdata_nxt   = WDATA;
    w_wstrb_nxt   = WSTRB;
    w_wvalid_nxt  = WVALID;
    w_bready_nxt  = BREADY;
    w_araddr_nxt  = ARADDR;
    w_arvalid_nxt = ARVALID;
    w_rready_nxt  = RREADY;

    case (state)
      S_IDLE: begin
        if (start) begin
          w_busy_nxt = 1'b1;
          if (write) begin
            // The AW/W registers double as the request latch.
            // They stay stable until the next accepted request.
            w_awaddr_nxt  = addr;
            w_wdata_nxt   = wdata;
            w_wstrb_nxt   = wstrb;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WRITE;
          end else begin
            w_araddr_nxt  = addr;
`ifdef AXI4LITE_MASTER_READ_EN
            w_arvalid_nxt = 1'b1;
`endif
            w_state_nxt   = S_RADDR;
          end
        end
      end

      S_WRITE: begin
        // AW and W complete independently.
        // A low VALID here means that channel's handshake has already completed.
        if (AWVALID && AWREADY) w_awvalid_nxt = 1'b0;
        if (WVALID && WREADY)   w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (BVALID) begin
          w_resp_nxt   = BRESP;
          w_bready_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end

`ifdef AXI4LITE_MASTER_READ_EN
      S_RADDR: begin
        if (ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (RVALID) begin
          w_rdata_nxt  = RDATA;
          w_resp_nxt   = RRESP;
          w_rready_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
`else
      // With no read path, a read spends one busy cycle here.
      // It then completes with SLVERR and leaves rdata untouched.
      S_RADDR: begin
        w_resp_nxt  = C_RESP_SLVERR;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end

      S_RDATA: begin
        w_state_nxt = S_IDLE;
      end
`endif

      S_DONE: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_master
//  Purpose  : Directed self-checking bench for axi4lite_master. The slave
//             handshakes are driven cycle by cycle from the stimulus block.
//  Config   : Follows AXI4LITE_MASTER_READ_EN. The read scenario checked
//             matches the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        start;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  axi4lite_master dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .start   (start),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .resp    (resp),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  // Inputs are driven and outputs are sampled there.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {25'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done}, 32'd0);
    check_eq({tag, "_awaddr"}, AWADDR, 32'd0);
    check_eq({tag, "_wdata"},  WDATA,  32'd0);
    check_eq({tag, "_wstrb"},  {28'd0, WSTRB}, 32'd0);
    check_eq({tag, "_araddr"}, ARADDR, 32'd0);
    check_eq({tag, "_rdata"},  rdata,  32'd0);
    check_eq({tag, "_resp"},   {30'd0, resp}, 32'd0);
  endtask

  // Write against a zero-wait slave.
  // READY is given in the first VALID cycle and BVALID right after.
  task automatic write_fast(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] br);
    start = 1'b1; write = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    start = 1'b0;
    check_eq({tag, "_awvalid_rise"}, {31'd0, AWVALID}, 32'd1);
    check_eq({tag, "_wvalid_rise"},  {31'd0, WVALID},  32'd1);
    check_eq({tag, "_busy"},         {31'd0, busy},    32'd1);
    check_eq({tag, "_awaddr"},       AWADDR, a);
    check_eq({tag, "_wdata"},        WDATA,  d);
    check_eq({tag, "_wstrb"},        {28'd0, WSTRB}, {28'd0, s});
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    check_eq({tag, "_valids_drop"}, {30'd0, AWVALID, WVALID}, 32'd0);
    check_eq({tag, "_bready"},      {31'd0, BREADY}, 32'd1);
    check_eq({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
    BVALID = 1'b1; BRESP = br;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    check_eq({tag, "_done"},       {31'd0, done},   32'd1);
    check_eq({tag, "_busy_done"},  {31'd0, busy},   32'd0);
    check_eq({tag, "_resp"},       {30'd0, resp},   {30'd0, br});
    check_eq({tag, "_bready_off"}, {31'd0, BREADY}, 32'd0);
    tick();
    check_eq({tag, "_done_once"},  {31'd0, done}, 32'd0);
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    ARESETn = 1'b1;
    start = 1'b0; write = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    ARREADY = 1'b0; RDATA = 32'd0; RRESP = 2'b00; RVALID = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check_outputs_zero("reset");
    ARESETn = 1'b0;
    tick();
    check_outputs_zero("post_reset_idle");

    // ---------------- zero-wait write ----------------
    write_fast("wr_fast", 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 2'b00);

    // ---------------- skewed write: AW 1 late, W 3 late ----------------
    start = 1'b1; write = 1'b1; addr = 32'h1000_0010; wdata = 32'h1234_5678; wstrb = 4'h3;
    tick();
    start = 1'b0;
    check_eq("skew_c1_valids", {30'd0, AWVALID, WVALID}, 32'd3);
    tick();
    check_eq("skew_c2_valids", {30'd0, AWVALID, WVALID}, 32'd3);
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    check_eq("skew_c3_aw_dropped", {30'd0, AWVALID, WVALID}, 32'd1);
    check_eq("skew_c3_no_bready",  {31'd0, BREADY}, 32'd0);
    check_eq("skew_c3_wdata_held", WDATA, 32'h1234_5678);
    tick();
    check_eq("skew_c4_w_held",    {30'd0, AWVALID, WVALID}, 32'd1);
    check_eq("skew_c4_no_bready", {31'd0, BREADY}, 32'd0);
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    check_eq("skew_c5_w_dropped", {30'd0, AWVALID, WVALID}, 32'd0);
    check_eq("skew_c5_bready",    {31'd0, BREADY}, 32'd1);
    BVALID = 1'b1; BRESP = 2'b01;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    check_eq("skew_done", {31'd0, done}, 32'd1);
    check_eq("skew_resp", {30'd0, resp}, 32'd1);
    tick();
    check_eq("skew_done_once", {31'd0, done}, 32'd0);

`ifdef AXI4LITE_MASTER_READ_EN
    // ---------------- read, ARREADY after 2 cycles ----------------
    start = 1'b1; write = 1'b0; addr = 32'h2000_0004;
    tick();
    start = 1'b0;
    check_eq("rd_arvalid", {31'd0, ARVALID}, 32'd1);
    check_eq("rd_araddr",  ARADDR, 32'h2000_0004);
    check_eq("rd_busy",    {31'd0, busy}, 32'd1);
    tick();
    check_eq("rd_arvalid_hold", {31'd0, ARVALID}, 32'd1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check_eq("rd_ar_drop", {30'd0, ARVALID, RREADY}, 32'd1);
    RVALID = 1'b1; RDATA = 32'hCAFE_F00D; RRESP = 2'b00;
    tick();
    RVALID = 1'b0; RDATA = 32'd0;
    check_eq("rd_done",   {31'd0, done}, 32'd1);
    check_eq("rd_rdata",  rdata, 32'hCAFE_F00D);
    check_eq("rd_resp",   {30'd0, resp}, 32'd0);
    check_eq("rd_rready_off", {31'd0, RREADY}, 32'd0);
    tick();
    check_eq("rd_done_once", {31'd0, done}, 32'd0);
    check_eq("rd_rdata_held", rdata, 32'hCAFE_F00D);
`else
    // ---------------- read with the read path compiled out ----------------
    start = 1'b1; write = 1'b0; addr = 32'h2000_0004;
    tick();
    start = 1'b0;
    check_eq("rdx_c1_arvalid", {31'd0, ARVALID}, 32'd0);
    check_eq("rdx_c1_busy",    {31'd0, busy},    32'd1);
    check_eq("rdx_c1_done",    {31'd0, done},    32'd0);
    tick();
    check_eq("rdx_c2_arvalid", {31'd0, ARVALID}, 32'd0);
    check_eq("rdx_c2_done",    {31'd0, done},    32'd1);
    check_eq("rdx_c2_resp",    {30'd0, resp},    32'd2);
    check_eq("rdx_c2_busy",    {31'd0, busy},    32'd0);
    check_eq("rdx_rdata_kept", rdata, 32'd0);
    tick();
    check_eq("rdx_done_once",  {31'd0, done},    32'd0);
`endif

    // ---------------- BRESP SLVERR with a second start while busy ----------------
    start = 1'b1; write = 1'b1; addr = 32'h3000_0000; wdata = 32'hA5A5_5A5A; wstrb = 4'h9;
    tick();
    // A second request appears during busy. It must be ignored.
    addr = 32'h3FFF_FFFC; wdata = 32'h0; wstrb = 4'h0;
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();
    start = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    check_eq("err_awaddr_latched", AWADDR, 32'h3000_0000);
    check_eq("err_wdata_latched",  WDATA,  32'hA5A5_5A5A);
    check_eq("err_bready", {31'd0, BREADY}, 32'd1);
    BVALID = 1'b1; BRESP = 2'b10;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    check_eq("err_done", {31'd0, done}, 32'd1);
    check_eq("err_resp", {30'd0, resp}, 32'd2);
    tick();
    check_eq("err_no_second_txn", {29'd0, AWVALID, WVALID, busy}, 32'd0);
    tick();
    check_eq("err_still_idle", {29'd0, AWVALID, WVALID, busy}, 32'd0);

    // ---------------- reset while W waits on WREADY ----------------
    start = 1'b1; write = 1'b1; addr = 32'h4000_0000; wdata = 32'h1111_2222; wstrb = 4'hF;
    tick();
    start = 1'b0;
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    check_eq("rst_mid_wvalid_wait", {30'd0, AWVALID, WVALID}, 32'd1);
    #1;
    ARESETn = 1'b1;
    #1;
    check_outputs_zero("rst_mid_async");
    tick();
    ARESETn = 1'b0;
    tick();
    check_eq("rst_mid_no_done", {31'd0, done}, 32'd0);
    write_fast("wr_after_rst", 32'h5000_0008, 32'h0BAD_F00D, 4'hC, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
